pc_sequencer: RTL
=================

# pc_sequencer

Instruction sequencer for the CPU controller: owns the program counter and steps it through fetch and execute. It requests each instruction from instruction memory with a req/ready handshake and executes NOP, JMP, BZ and HALT. It updates the PC with wrap-around, branch loads and halt/restart control, and faults on a fetch timeout. It sits between the instruction memory port and the rest of the controller.

## Interface
- PC_WIDTH, 3, program counter width; address space is 2^PC_WIDTH
- TIMEOUT, 8, consecutive FETCH cycles without mem_ready before fault (≥1)
- clk  input  1  system clock, rising edge
- rstn  input  1  reset, asynchronous, active-low
- start  input  1  leave IDLE, or restart from HALT; ignored in FETCH/EXEC
- mem_ready  input  1  instruction memory ack; instr_* valid this cycle; ignored outside FETCH
- instr_op  input  2  opcode: 00 NOP, 01 JMP, 10 BZ, 11 HALT
- instr_target  input  PC_WIDTH  branch/jump target
- zero_flag  input  1  datapath zero flag, sampled in EXEC
- mem_req  output  1  instruction fetch request for address pc
- pc  output  PC_WIDTH  current program counter
- state  output  2  debug: 0 IDLE, 1 FETCH, 2 EXEC, 3 HALT
- exec_valid  output  1  high for the single EXEC cycle
- halted  output  1  high while in HALT
- fault  output  1  sticky fetch-timeout flag

## Operation
- Reset (rstn low, async): state IDLE, pc 0, fault 0, wait counter 0, instruction register 0.
- mem_req, exec_valid and halted are Moore decodes of the registered state: mem_req = (state==FETCH), exec_valid = (state==EXEC), halted = (state==HALT).
- IDLE: start=1 moves to FETCH. pc is held.
- FETCH:
  - mem_req=1 and the address is pc.
  - mem_ready=1: latch instr_op and instr_target into the instruction register, clear the wait counter, move to EXEC.
  - mem_ready=0: increment the wait counter.
  - If the counter reaches TIMEOUT (TIMEOUT consecutive low cycles), move to HALT and set fault=1. pc is unchanged.
  - mem_ready=1 on the TIMEOUT-th cycle wins: the fetch is accepted and there is no fault.
- EXEC: lasts one cycle and uses the latched instruction.
  - NOP: pc := pc+1 mod 2^PC_WIDTH; go to FETCH.
  - JMP: pc := target; go to FETCH.
  - BZ: if zero_flag, pc := target, else pc+1 with wrap; go to FETCH.
  - HALT: pc unchanged; go to HALT.
- HALT: holds pc and fault. start=1 sets pc := 0, clears fault, and moves to FETCH.
- The wait counter clears on every entry to FETCH. Its width is clog2(TIMEOUT+1).

## Timing
- start sampled at edge N: state=FETCH and mem_req=1 from cycle N+1.
- Zero-wait memory (mem_ready=1 in the first FETCH cycle): each instruction takes 2 cycles (FETCH, EXEC).
- Each wait cycle adds 1 cycle; mem_req stays high until the cycle mem_ready is sampled high.
- The new pc is visible in the cycle after EXEC, which is the next FETCH. The memory address for that fetch is the updated pc.
- instr_op and instr_target are sampled only on the FETCH edge where mem_ready=1. Changes during EXEC have no effect.
- zero_flag is sampled only on the EXEC edge.
- Reset asserted mid-instruction forces IDLE, pc 0 and all outputs low immediately, without waiting for a clock edge. After release, the block waits in IDLE for start.
- No outputs are combinational from inputs.

## Test plan
- Reset: hold rstn=0 15 ns, then release → pc=0, state=0, mem_req/exec_valid/halted/fault=0. Assert rstn mid-FETCH → outputs clear immediately with no clock edge.
- NOP stream, mem_ready=1 always: pulse start → pc steps 0,1,…,7,0 every 2 cycles (wrap at 8). exec_valid pulses once per instruction.
- Branches: at pc=2, JMP target 5 → pc=5. BZ target 1 with zero_flag=0 → pc=6. BZ target 1 with zero_flag=1 → pc=1.
- Wait states: mem_ready low 3 cycles then high → mem_req high for 4 cycles, pc stable throughout, EXEC follows, fault=0.
- Timeout, TIMEOUT=8: mem_ready held 0 → after 8 FETCH cycles state=3, halted=1, fault=1, pc unchanged. Then start → pc=0, fault=0, FETCH. A repeat with mem_ready=1 on the 8th cycle → EXEC, no fault.
- HALT opcode at pc=3 → halted=1, pc stays 3 for 10 cycles while start=0. start=1 → pc=0, FETCH.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: instruction-memory fetch handshake between the sequencer and memory
//   mem_req      sequencer -> memory : fetch request for the sequencer's current pc
//   mem_ready    memory -> sequencer : instruction word valid this cycle
//   instr_op     memory -> sequencer : opcode (00 NOP, 01 JMP, 10 BZ, 11 HALT)
//   instr_target memory -> sequencer : jump/branch target
interface pc_sequencer_if #(
    parameter int PC_WIDTH = 3
);
    logic                mem_req;
    logic                mem_ready;
    logic [1:0]          instr_op;
    logic [PC_WIDTH-1:0] instr_target;
    modport master (output mem_req, input mem_ready, instr_op, instr_target);
    modport slave  (input mem_req, output mem_ready, instr_op, instr_target);
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter owner stepping FETCH/EXEC for NOP, JMP, BZ, HALT
//   clk, rstn         clock and asynchronous active-low reset
//   start             leave IDLE or restart from HALT
//   zero_flag         datapath zero flag, used by BZ in EXEC
//   mem               fetch handshake (master side)
//   pc, state         program counter and debug state (0 IDLE,1 FETCH,2 EXEC,3 HALT)
//   exec_valid/halted Moore decodes of the state
//   fault             sticky fetch-timeout flag, cleared by restart from HALT
module pc_sequencer #(
    parameter int PC_WIDTH = 3,
    parameter int TIMEOUT  = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 zero_flag,
    pc_sequencer_if.master       mem,
    output logic [PC_WIDTH-1:0]  pc,
    output logic [1:0]           state,
    output logic                 exec_valid,
    output logic                 halted,
    output logic                 fault
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;
    state_t              r_state, w_state_nxt;
    logic [PC_WIDTH-1:0] r_pc, w_pc_nxt, r_tgt, w_tgt_nxt, w_pc_inc;
    logic [1:0]          r_op, w_op_nxt;
    logic [CW-1:0]       r_cnt, w_cnt_nxt, w_cnt_inc;
    logic                r_fault, w_fault_nxt;
    assign w_pc_inc  = r_pc + PC_WIDTH'(1);
    assign w_cnt_inc = r_cnt + CW'(1);
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_fault <= 1'b0;
            r_cnt   <= '0;
            r_op    <= '0;
            r_tgt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_fault <= w_fault_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
            r_tgt   <= w_tgt_nxt;
        end
    end
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_fault_nxt = r_fault;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        w_tgt_nxt   = r_tgt;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_FETCH;
                    w_cnt_nxt   = '0;
                end
            end
            S_FETCH: begin
                // an ack on the final allowed cycle is still accepted
                if (mem.mem_ready) begin
                    w_op_nxt    = mem.instr_op;
                    w_tgt_nxt   = mem.instr_target;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_EXEC;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == CW'(TIMEOUT)) begin
                        w_state_nxt = S_HALT;
                        w_fault_nxt = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                w_cnt_nxt   = '0;
                w_state_nxt = (r_op == 2'b11) ? S_HALT : S_FETCH;
                w_pc_nxt    = (r_op == 2'b00) ? w_pc_inc :
                              (r_op == 2'b01) ? r_tgt :
                              (r_op == 2'b10) ? (zero_flag ? r_tgt : w_pc_inc) : r_pc;
            end
            S_HALT: begin
                if (start) begin
                    w_pc_nxt    = '0;
                    w_fault_nxt = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_FETCH;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end
    assign mem.mem_req = (r_state == S_FETCH);
    assign exec_valid  = (r_state == S_EXEC);
    assign halted      = (r_state == S_HALT);
    assign pc          = r_pc;
    assign state       = r_state;
    assign fault       = r_fault;
endmodule
